// File: rtl/wave_gen_dds.sv
// rtl/wave_gen_dds.sv - DDS waveform generator (triangle/saw/square/DC) for the DAC path
// Phase accumulator plus three registered stages: shape, amplitude scale, offset with saturation.
module wave_gen_dds #(
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 32,
    parameter int AMP_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               cfg_load,
    input  logic [PHASE_W-1:0] cfg_freq,
    input  logic [PHASE_W-1:0] cfg_phase,
    input  logic [1:0]         cfg_mode,
    input  logic [AMP_W-1:0]   cfg_amp,
    input  logic [DATA_W-1:0]  cfg_offset,
    output logic               cfg_busy,
    output logic               phase_sync,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid
);

    localparam int U_W    = DATA_W + 1;
    localparam int PROD_W = DATA_W + AMP_W + 1;

    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_freq, r_phase;
    logic [1:0]         r_mode;
    logic [AMP_W-1:0]   r_amp;
    logic [DATA_W-1:0]  r_offset;
    logic [PHASE_W-1:0] r_sh_freq, r_sh_phase;
    logic [1:0]         r_sh_mode;
    logic [AMP_W-1:0]   r_sh_amp;
    logic [DATA_W-1:0]  r_sh_offset;
    logic               r_busy;
    logic               r_sync;
    logic [DATA_W-1:0]  r_shape;
    logic [DATA_W-1:0]  r_scaled;
    logic [DATA_W-1:0]  r_dout;
    logic [2:0]         r_valid;

    logic [PHASE_W:0]   w_acc_sum;
    logic               w_wrap;
    logic               w_direct;
    logic               w_apply;
    logic [PHASE_W-1:0] w_p;
    logic [U_W-1:0]     w_u;
    logic [DATA_W-1:0]  w_shape;
    logic [AMP_W:0]     w_gain;
    logic [PROD_W-1:0]  w_prod;
    logic [DATA_W:0]    w_off_sum;

    assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_freq};
    assign w_wrap    = en & w_acc_sum[PHASE_W];
    // A stopped or idle generator has no period boundary to wait for.
    assign w_direct  = ~en | (r_freq == '0);
    assign w_apply   = r_busy & (w_wrap | ~en);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_freq      <= '0;
            r_phase     <= '0;
            r_mode      <= 2'd0;
            r_amp       <= '1;
            r_offset    <= '0;
            r_sh_freq   <= '0;
            r_sh_phase  <= '0;
            r_sh_mode   <= 2'd0;
            r_sh_amp    <= '0;
            r_sh_offset <= '0;
            r_busy      <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            if (en) begin
                r_acc <= w_acc_sum[PHASE_W-1:0];
            end
            r_sync <= w_wrap;
            if (w_apply) begin
                r_freq   <= r_sh_freq;
                r_phase  <= r_sh_phase;
                r_mode   <= r_sh_mode;
                r_amp    <= r_sh_amp;
                r_offset <= r_sh_offset;
                r_busy   <= 1'b0;
            end
            // A load later in this block wins over a shadow apply on the same edge.
            if (cfg_load) begin
                if (w_direct) begin
                    r_freq   <= cfg_freq;
                    r_phase  <= cfg_phase;
                    r_mode   <= cfg_mode;
                    r_amp    <= cfg_amp;
                    r_offset <= cfg_offset;
                    r_busy   <= 1'b0;
                end else begin
                    r_sh_freq   <= cfg_freq;
                    r_sh_phase  <= cfg_phase;
                    r_sh_mode   <= cfg_mode;
                    r_sh_amp    <= cfg_amp;
                    r_sh_offset <= cfg_offset;
                    r_busy      <= 1'b1;
                end
            end
        end
    end

    assign w_p = r_acc + r_phase;
    assign w_u = U_W'(w_p >> (PHASE_W - U_W));

    always_comb begin
        w_shape = '0;
        case (r_mode)
            2'd0:    w_shape = w_u[DATA_W] ? ~w_u[DATA_W-1:0] : w_u[DATA_W-1:0];
            2'd1:    w_shape = w_u[DATA_W:1];
            2'd2:    w_shape = {DATA_W{w_u[DATA_W]}};
            default: w_shape = '1;
        endcase
    end

    // Gain of amp+1 over 2^AMP_W makes all-ones amp an exact pass-through.
    assign w_gain    = {1'b0, r_amp} + (AMP_W + 1)'(1);
    assign w_prod    = PROD_W'(r_shape) * PROD_W'(w_gain);
    assign w_off_sum = {1'b0, r_scaled} + {1'b0, r_offset};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shape  <= '0;
            r_scaled <= '0;
            r_dout   <= '0;
            r_valid  <= 3'b000;
        end else begin
            r_shape  <= w_shape;
            r_scaled <= DATA_W'(w_prod >> AMP_W);
            r_dout   <= w_off_sum[DATA_W] ? '1 : w_off_sum[DATA_W-1:0];
            r_valid  <= {r_valid[1:0], en};
        end
    end

    assign cfg_busy   = r_busy;
    assign phase_sync = r_sync;
    assign dout       = r_dout;
    assign dout_valid = r_valid[2];

endmodule

// File: tb/tb_wave_gen_dds.sv
// tb/tb_wave_gen_dds.sv - self-checking bench for wave_gen_dds
// Reference model tracks accumulator/config per cycle and computes samples arithmetically.
module tb_wave_gen_dds;

    localparam int DW = 8;
    localparam int PW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          cfg_load = 1'b0;
    logic [PW-1:0] cfg_freq = '0;
    logic [PW-1:0] cfg_phase = '0;
    logic [1:0]    cfg_mode = 2'd0;
    logic [AW-1:0] cfg_amp = '0;
    logic [DW-1:0] cfg_offset = '0;
    logic          cfg_busy;
    logic          phase_sync;
    logic [DW-1:0] dout;
    logic          dout_valid;

    wave_gen_dds #(.DATA_W(DW), .PHASE_W(PW), .AMP_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_load   (cfg_load),
        .cfg_freq   (cfg_freq),
        .cfg_phase  (cfg_phase),
        .cfg_mode   (cfg_mode),
        .cfg_amp    (cfg_amp),
        .cfg_offset (cfg_offset),
        .cfg_busy   (cfg_busy),
        .phase_sync (phase_sync),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] freq;
        logic [31:0] phase;
        logic [1:0]  mode;
        logic [7:0]  amp;
        logic [7:0]  offset;
    } cfg_t;

    typedef struct {
        logic [31:0] acc;
        cfg_t        c;
    } rec_t;

    cfg_t        m_cfg, m_sh;
    logic [31:0] m_acc;
    bit          m_busy, m_sync;
    rec_t        hist[$];
    bit          en_hist[$];
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic int ref_sample(logic [31:0] acc, logic [31:0] phase, logic [1:0] mode,
                                      logic [7:0] amp, logic [7:0] offset);
        longint unsigned a = acc;
        longint unsigned b = phase;
        longint unsigned p = (a + b) % (64'd1 << PW);
        int pos, shape, s;
        case (mode)
            2'd0: begin
                pos   = int'(p / (64'd1 << (PW - DW - 1)));
                shape = (pos < 256) ? pos : 511 - pos;
            end
            2'd1:    shape = int'(p / (64'd1 << (PW - DW)));
            2'd2:    shape = (p >= (64'd1 << (PW - 1))) ? 255 : 0;
            default: shape = 255;
        endcase
        s = shape * (int'(amp) + 1) / 256 + int'(offset);
        return (s > 255) ? 255 : s;
    endfunction

    function automatic cfg_t cur_cfg();
        cfg_t c;
        c.freq = cfg_freq; c.phase = cfg_phase; c.mode = cfg_mode;
        c.amp = cfg_amp; c.offset = cfg_offset;
        return c;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit              l_rst, l_en, l_load, wrap, apply;
        cfg_t            l_c;
        longint unsigned sum;
        logic [31:0]     old_freq;
        rec_t            r;
        l_rst = rst_n; l_en = en; l_load = cfg_load; l_c = cur_cfg();
        @(posedge clk);
        #1;
        if (!l_rst) begin
            m_acc = '0;
            m_cfg.freq = '0; m_cfg.phase = '0; m_cfg.mode = 2'd0; m_cfg.amp = 8'hFF; m_cfg.offset = '0;
            m_sh.freq = '0; m_sh.phase = '0; m_sh.mode = 2'd0; m_sh.amp = '0; m_sh.offset = '0;
            m_busy = 0; m_sync = 0;
            hist.delete(); en_hist.delete();
            r.acc = m_acc; r.c = m_cfg;
            repeat (4) hist.push_back(r);
            repeat (3) en_hist.push_back(1'b0);
        end else begin
            sum      = longint'(m_acc) + longint'(m_cfg.freq);
            wrap     = l_en && (sum >= (64'd1 << PW));
            apply    = m_busy && (wrap || !l_en);
            old_freq = m_cfg.freq;
            m_sync   = wrap;
            if (l_en) m_acc = 32'(sum);
            if (apply) begin m_cfg = m_sh; m_busy = 0; end
            if (l_load) begin
                if (!l_en || old_freq == 0) begin m_cfg = l_c; m_busy = 0; end
                else begin m_sh = l_c; m_busy = 1; end
            end
            r.acc = m_acc; r.c = m_cfg;
            hist.push_back(r);
            en_hist.push_back(l_en);
        end
        while (hist.size() > 4) void'(hist.pop_front());
        while (en_hist.size() > 3) void'(en_hist.pop_front());
        chk("dout", dout, ref_sample(hist[0].acc, hist[0].c.phase, hist[0].c.mode,
                                     hist[1].c.amp, hist[2].c.offset));
        chk("dout_valid", dout_valid, en_hist[0]);
        chk("cfg_busy", cfg_busy, m_busy);
        chk("phase_sync", phase_sync, m_sync);
    endtask

    task automatic set_cfg(logic [31:0] f, logic [31:0] p, logic [1:0] md, logic [7:0] a, logic [7:0] o);
        cfg_freq = f; cfg_phase = p; cfg_mode = md; cfg_amp = a; cfg_offset = o;
    endtask

    task automatic load(logic [31:0] f, logic [31:0] p, logic [1:0] md, logic [7:0] a, logic [7:0] o);
        set_cfg(f, p, md, a, o);
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic wait_idle(string tag);
        int k = 0;
        while (cfg_busy && k < 3000) begin step(); k++; end
        chk(tag, (k < 3000), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; step(); rst_n = 1'b1;
    endtask

    initial begin
        int last, cnt, k;
        logic [7:0] d0;

        rst_n = 1'b0;
        cfg_load = 1'b1;
        set_cfg(32'h0100_0000, 32'h1234_5678, 2'd3, 8'h55, 8'h20);
        step();
        cfg_load = 1'b0;
        step();
        chk("rst_dout", dout, 0);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_valid", dout_valid, 0);
        rst_n = 1'b1;

        // Triangle, 512-clock period
        load(32'h0080_0000, 32'h0, 2'd0, 8'hFF, 8'h00);
        en = 1'b1;
        last = -1;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (phase_sync) begin
                if (last >= 0) chk("sync_period", i - last, 512);
                last = i;
            end
        end
        chk("sync_seen", (last >= 0), 1);

        // Square at half amplitude
        load(32'h0080_0000, 32'h0, 2'd2, 8'h7F, 8'h00);
        wait_idle("sq_idle");
        run(8);
        cnt = 0;
        for (int i = 0; i < 512; i++) begin
            step();
            if (dout == 8'h7F) cnt++;
        end
        chk("sq_high_cnt", cnt, 256);

        // DC with offset, saturating and not
        load(32'h0080_0000, 32'h0, 2'd3, 8'hFF, 8'h10);
        wait_idle("dc1_idle");
        run(4);
        chk("dc_sat", dout, 8'hFF);
        load(32'h0080_0000, 32'h0, 2'd3, 8'h7F, 8'h10);
        wait_idle("dc2_idle");
        run(4);
        chk("dc_8f", dout, 8'h8F);

        // Frequency change deferred to the wrap
        en = 1'b0;
        do_reset();
        load(32'h0080_0000, 32'h0, 2'd1, 8'hFF, 8'h00);
        en = 1'b1;
        run(128);
        load(32'h0100_0000, 32'h0, 2'd1, 8'hFF, 8'h00);
        chk("t4_busy_set", cfg_busy, 1);
        k = 1;
        while (cfg_busy && k < 1000) begin step(); k++; end
        chk("t4_busy_clocks", k, 384);
        chk("t4_sync", phase_sync, 1);
        run(5);
        d0 = dout;
        step();
        chk("t4_new_step", 8'(dout - d0), 1);

        // Phase offset and en freeze
        en = 1'b0;
        do_reset();
        load(32'h0080_0000, 32'h8000_0000, 2'd0, 8'hFF, 8'h00);
        en = 1'b1;
        k = 0;
        while (!dout_valid && k < 10) begin step(); k++; end
        chk("t5_first", dout, 8'hFF);
        run(20);
        en = 1'b0;
        run(2);
        chk("t5_valid_2", dout_valid, 1);
        step();
        chk("t5_valid_3", dout_valid, 0);
        run(7);
        en = 1'b1;
        run(10);

        // Reset while busy discards the shadow
        load(32'h0100_0000, 32'h0, 2'd2, 8'hFF, 8'h00);
        chk("t6_busy", cfg_busy, 1);
        do_reset();
        chk("t6_busy_clr", cfg_busy, 0);
        chk("t6_dout", dout, 0);
        chk("t6_valid", dout_valid, 0);
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (phase_sync || dout != 0) cnt++;
        end
        chk("t6_idle", cnt, 0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) en = ~en;
            if ($urandom_range(0, 40) == 0) begin
                set_cfg(($urandom_range(0, 7) == 0) ? 32'h0 : $urandom_range(32'h0040_0000, 32'h0800_0000),
                        $urandom, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
                cfg_load = 1'b1;
            end else begin
                cfg_load = 1'b0;
            end
            rst_n = ($urandom_range(0, 500) != 0);
            step();
        end
        cfg_load = 1'b0;
        rst_n = 1'b1;
        run(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
